// File: rtl/mux_scan_pkg.sv
// Shared constants for the 4:1 mux scan controller: channel count, select
// width, dwell counter width and FSM state encoding.
package mux_scan_pkg;
    localparam int N_CH    = 4;
    localparam int SEL_W   = 2;
    localparam int DWELL_W = 4;

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_SCAN = 2'd1;
    localparam state_t S_DONE = 2'd2;
endpackage

// File: rtl/dwell_timer.sv
// Dwell counter: counts while enabled and raises tick on the last cycle of
// each DWELL-cycle window, then wraps to zero.
module dwell_timer
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);
    if (DWELL < 1 || DWELL > 15) begin : g_bad_dwell
        $error("dwell_timer: DWELL must be in 1..15");
    end

    localparam logic [DWELL_W-1:0] LAST = DWELL_W'(DWELL - 1);

    logic [DWELL_W-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + DWELL_W'(1);
    end
endmodule

// File: rtl/mux_scan_ctrl.sv
// Drives a 4:1 mux with a latched word, steps its select 0..3 and reassembles
// the mux output into dout, flagging err when it differs from the driven word.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N_CH-1:0]  din,
    output logic             ready,
    output logic             busy,
    output logic [N_CH-1:0]  mux_i,
    output logic [SEL_W-1:0] mux_sel,
    input  logic             mux_o,
    output logic [N_CH-1:0]  dout,
    output logic             done,
    output logic             err
);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_CH - 1);

    state_t            state, state_nxt;
    logic [N_CH-2:0]   cap;
    logic [N_CH-1:0]   word_fin;
    logic              tick;
    logic              launch;
    logic              last_smp;

    assign launch   = (state == S_IDLE) && start;
    assign last_smp = (state == S_SCAN) && tick && (mux_sel == SEL_LAST);
    // The final channel is taken straight from mux_o, so the compare needs no extra cycle.
    assign word_fin = {mux_o, cap};

    dwell_timer #(.DWELL(DWELL)) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .clr  (launch),
        .en   (state == S_SCAN),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_SCAN;
            S_SCAN:  if (last_smp) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ready = (state == S_IDLE);
        busy  = (state == S_SCAN) || (state == S_DONE);
        done  = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mux_i   <= '0;
            mux_sel <= '0;
            cap     <= '0;
            dout    <= '0;
            err     <= 1'b0;
        end else if (launch) begin
            mux_i   <= din;
            mux_sel <= '0;
            cap     <= '0;
        end else if (state == S_SCAN && tick) begin
            if (mux_sel == SEL_LAST) begin
                dout <= word_fin;
                err  <= (word_fin != mux_i);
            end else begin
                cap[mux_sel] <= mux_o;
                mux_sel      <= mux_sel + SEL_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench: a DWELL=1 controller on a bench mux (with stuck-at-0 fault
// option) and a DWELL=3 controller on a clean mux.
module tb_mux_scan_ctrl;
    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      start;
    logic [1:0][3:0] din, mux_i, dout;
    logic [1:0][1:0] mux_sel;
    logic [1:0]      ready, busy, mux_o, done, err;
    logic            force0;
    int              pass = 0;
    int              total = 0;

    always #5 clk = ~clk;

    assign mux_o[0] = force0 ? 1'b0 : mux_i[0][mux_sel[0]];
    assign mux_o[1] = mux_i[1][mux_sel[1]];

    mux_scan_ctrl #(.DWELL(1)) u0 (
        .clk(clk), .rst(rst), .start(start[0]), .din(din[0]), .ready(ready[0]),
        .busy(busy[0]), .mux_i(mux_i[0]), .mux_sel(mux_sel[0]), .mux_o(mux_o[0]),
        .dout(dout[0]), .done(done[0]), .err(err[0])
    );
    mux_scan_ctrl #(.DWELL(3)) u1 (
        .clk(clk), .rst(rst), .start(start[1]), .din(din[1]), .ready(ready[1]),
        .busy(busy[1]), .mux_i(mux_i[1]), .mux_sel(mux_sel[1]), .mux_o(mux_o[1]),
        .dout(dout[1]), .done(done[1]), .err(err[1])
    );

    typedef struct {
        logic [3:0] d;
        logic       f;
        logic [3:0] exp_dout;
        logic       exp_err;
    } vec_t;

    vec_t vt[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Launch a scan on unit u; report the edge index (after E0) where done was
    // first seen and how many done cycles occurred before ready returned.
    task automatic scan(input int u, input logic [3:0] d, output int done_at, output int pulses);
        done_at = -1;
        pulses  = 0;
        start[u] = 1'b1;
        din[u]   = d;
        step();
        start[u] = 1'b0;
        for (int n = 1; n <= 80; n++) begin
            step();
            if (done[u]) begin
                pulses++;
                if (done_at < 0) done_at = n;
            end
            if (done_at >= 0 && ready[u]) break;
        end
    endtask

    initial begin
        int da, np, bad;

        vt[0] = '{4'b0101, 1'b0, 4'b0101, 1'b0};
        vt[1] = '{4'b0110, 1'b1, 4'b0000, 1'b1};
        vt[2] = '{4'b0011, 1'b0, 4'b0011, 1'b0};
        vt[3] = '{4'b1111, 1'b0, 4'b1111, 1'b0};
        vt[4] = '{4'b0000, 1'b0, 4'b0000, 1'b0};
        vt[5] = '{4'b1000, 1'b0, 4'b1000, 1'b0};
        vt[6] = '{4'b1001, 1'b1, 4'b0000, 1'b1};

        rst = 1'b1; start = '0; din = '0; force0 = 1'b0;
        step();
        step();
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("rst_ready%0d", u), ready[u], 1);
            chk($sformatf("rst_busy%0d", u), busy[u], 0);
            chk($sformatf("rst_dout%0d", u), dout[u], 0);
            chk($sformatf("rst_sel%0d", u), mux_sel[u], 0);
            chk($sformatf("rst_done%0d", u), done[u], 0);
        end
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (!ready[0] || busy[0] || done[0] || dout[0] != 0 || mux_sel[0] != 0) bad++;
        end
        chk("idle_hold", bad, 0);

        // Select stepping and done timing with DWELL=1.
        start[0] = 1'b1; din[0] = 4'b0101;
        step();
        start[0] = 1'b0;
        chk("e0_sel", mux_sel[0], 0);
        chk("e0_busy", busy[0], 1);
        chk("e0_ready", ready[0], 0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("e%0d_sel", k), mux_sel[0], (k > 3) ? 3 : k);
            chk($sformatf("e%0d_done", k), done[0], (k == 4) ? 1 : 0);
        end
        step();
        chk("e5_ready", ready[0], 1);
        chk("e5_done", done[0], 0);
        chk("basic_dout", dout[0], 4'b0101);
        chk("basic_err", err[0], 0);

        // Table of scans on the DWELL=1 unit, some through a stuck-at-0 mux.
        foreach (vt[i]) begin
            force0 = vt[i].f;
            scan(0, vt[i].d, da, np);
            chk($sformatf("v%0d_done_at", i), da, 4);
            chk($sformatf("v%0d_pulses", i), np, 1);
            chk($sformatf("v%0d_dout", i), dout[0], vt[i].exp_dout);
            chk($sformatf("v%0d_err", i), err[0], vt[i].exp_err);
        end
        force0 = 1'b0;

        // dout/err survive a new start until the next completion.
        start[0] = 1'b1; din[0] = 4'b1100;
        step();
        start[0] = 1'b0;
        step();
        step();
        chk("hold_dout", dout[0], 0);
        chk("hold_err", err[0], 1);
        step();
        step();
        step();
        chk("hold_new_dout", dout[0], 4'b1100);
        chk("hold_new_err", err[0], 0);
        step();

        // DWELL=3: each select held three cycles, done after E12.
        start[1] = 1'b1; din[1] = 4'b1000;
        step();
        start[1] = 1'b0;
        bad = 0; np = 0; da = -1;
        chk("d3_e0_sel", mux_sel[1], 0);
        for (int k = 1; k <= 12; k++) begin
            step();
            if (mux_sel[1] != ((k / 3 > 3) ? 3 : k / 3)) bad++;
            if (done[1]) begin np++; if (da < 0) da = k; end
        end
        chk("d3_sel_seq", bad, 0);
        chk("d3_done_at", da, 12);
        chk("d3_pulses", np, 1);
        chk("d3_dout", dout[1], 4'b1000);
        chk("d3_err", err[1], 0);
        step();
        chk("d3_ready", ready[1], 1);

        // Start pulses and din changes while busy are ignored.
        start[0] = 1'b1; din[0] = 4'b1010;
        step();
        start[0] = 1'b0;
        step();
        start[0] = 1'b1; din[0] = 4'b0001;
        np = 0;
        for (int k = 2; k <= 5; k++) begin
            step();
            if (done[0]) np++;
        end
        start[0] = 1'b0;
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (done[0]) np++;
            if (busy[0]) bad++;
        end
        chk("ign_pulses", np, 1);
        chk("ign_no_rescan", bad, 0);
        chk("ign_dout", dout[0], 4'b1010);
        chk("ign_err", err[0], 0);

        // Reset while mux_sel=2 abandons the scan.
        start[0] = 1'b1; din[0] = 4'b0110;
        step();
        start[0] = 1'b0;
        step();
        step();
        chk("mr_sel_before", mux_sel[0], 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_ready", ready[0], 1);
        chk("mr_busy", busy[0], 0);
        chk("mr_sel", mux_sel[0], 0);
        chk("mr_dout", dout[0], 0);
        np = 0;
        for (int k = 0; k < 8; k++) begin
            if (done[0]) np++;
            step();
        end
        chk("mr_no_done", np, 0);
        scan(0, 4'b1111, da, np);
        chk("mr_rescan_done_at", da, 4);
        chk("mr_rescan_dout", dout[0], 4'b1111);
        chk("mr_rescan_err", err[0], 0);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Upstream sequencer and downstream collector for the 4:1 dataflow mux.
- Accepts a 4-bit word, drives the mux data input and steps the mux select 0..3 in turn.
- Samples the mux output at each select and returns the reassembled word, with a done pulse and a mismatch flag.
- Used to drive and self-check the mux in hardware, replacing the open-loop stimulus sequence.

Parameters:
- DWELL, 1, clock cycles each select value is held before mux output is sampled; range 1..15; DWELL=0 is an elaboration error.
- N_CH, 4, mux channel count; fixed, taken from the package, not user-overridable.
- SEL_W, 2, select width, log2(N_CH); from the package.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request scan of din; accepted only when ready=1
- din  in  4  word to scan; sampled on the accepting edge
- ready  out  1  high in IDLE only
- busy  out  1  high in SCAN and DONE
- mux_i  out  4  registered; drives mux I
- mux_sel  out  2  registered; drives mux sel
- mux_o  in  1  mux output O, combinational from mux_i/mux_sel
- dout  out  4  reassembled word; dout[k] = mux_o sampled while mux_sel=k
- done  out  1  one-cycle pulse on completion
- err  out  1  registered with dout; 1 if reassembled word != mux_i

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, mux_i=0, mux_sel=0, dwell_cnt=0, cap=0, dout=0, done=0, err=0. ready=1 and busy=0 from the first reset edge. Reset overrides every other event, including mid-scan; a scan in progress is abandoned with no done pulse.
- States: IDLE, SCAN, DONE.
- IDLE:
  - Edge with start=1: mux_i<=din, mux_sel<=0, dwell_cnt<=0, cap<=0, go to SCAN.
  - start=0: hold. mux_i and mux_sel keep their last values.
- SCAN, each edge:
  - If dwell_cnt < DWELL-1: dwell_cnt++.
  - Otherwise: cap[mux_sel]<=mux_o and dwell_cnt<=0.
  - On that sampling edge, if mux_sel==3: dout<=cap with bit 3 replaced by mux_o; err<=(that value != mux_i); go to DONE. Otherwise mux_sel++.
- DONE: done=1 for exactly this one cycle; next edge goes to IDLE. mux_sel stays at 3.
- Latency: the start edge is E0. done is high in the cycle after edge E(4*DWELL). With DWELL=1, done is high in the cycle after E4. Back-to-back minimum start spacing is 4*DWELL+2 edges.
- start while busy=1 (SCAN or DONE) is ignored, not queued. start held high continuously re-launches on every IDLE cycle.
- din changes during a scan have no effect, because mux_i is latched.
- dout and err hold their values until the next completion. They are not cleared on start.
- Sampling point: mux_o is sampled on the final dwell edge of each select, i.e. at least one full cycle after mux_sel/mux_i are updated, so combinational mux settling is covered.
- mux_sel wraps only via the reload on the next start, never by incrementing past 3.

Decomposition:
- Package mux_scan_pkg holds:
  - N_CH=4 and SEL_W=2
  - state encoding constants S_IDLE=2'd0, S_SCAN=2'd1, S_DONE=2'd2
  - DWELL_W=4 (dwell counter width)
- Sub-module dwell_timer holds the dwell counter:
  - inputs clk, rst, clr, en
  - output tick, high when count==DWELL-1
  - parameter DWELL
- All else (FSM, cap, select stepping, compare) stays in mux_scan_ctrl.

Test Plan:
- Reset then idle: rst high 2 cycles → ready=1, busy=0, dout=0, mux_sel=0, done=0. Hold 10 cycles with start=0 → no change.
- Basic scan, DWELL=1, real mux attached: din=4'b0101, start one cycle → mux_sel steps 0,1,2,3 on consecutive cycles; done pulses once after E4; dout=4'b0101, err=0; ready returns the next cycle.
- Dwell timing, DWELL=3: din=4'b1000 → each mux_sel value held 3 cycles; done after E12; dout=4'b1000, err=0.
- Fault injection: mux_o forced to 0 by bench, din=4'b0110 → dout=4'b0000, err=1. Next scan with a real mux and din=4'b0011 → dout=4'b0011, err=0.
- Ignored start and din change: start pulses during SCAN and DONE, din changed mid-scan from 4'b1010 to 4'b0001 → single done pulse, dout=4'b1010, no second scan.
- Reset mid-operation: rst asserted while mux_sel=2 → next cycle state IDLE, mux_sel=0, dout=0, no done. A fresh start with din=4'b1111 → dout=4'b1111.
